// File: rtl/jk_reg_bank_pkg.sv
// Shared definitions for the JK register bank: bank mode encoding and its width.
package jk_reg_bank_pkg;

    localparam int unsigned JK_MODE_W = 2;

    typedef enum logic [JK_MODE_W-1:0] {
        JK_MODE_JK   = 2'd0,
        JK_MODE_UP   = 2'd1,
        JK_MODE_DOWN = 2'd2,
        JK_MODE_LOAD = 2'd3
    } jk_mode_e;

endpackage

// File: rtl/jk_cell.sv
// Single-bit JK flop with update enable and asynchronous active-high reset to a
// per-cell reset value.
module jk_cell (
    input  logic clk,
    input  logic reset,
    input  logic i_rst_val,
    input  logic i_en,
    input  logic i_j,
    input  logic i_k,
    output logic o_q
);

    logic r_q;

    // Classic JK behaviour: hold, clear, set, toggle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q <= i_rst_val;
        end else if (i_en) begin
            unique case ({i_j, i_k})
                2'b00:   r_q <= r_q;
                2'b01:   r_q <= 1'b0;
                2'b10:   r_q <= 1'b1;
                default: r_q <= ~r_q;
            endcase
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/jk_reg_bank.sv
// WIDTH-bit register bank of JK cells with JK, count up/down and parallel load
// modes, plus a registered roll-over pulse.
// Build option: define JK_REG_BANK_SAT_EN to make counting saturate at the
// ends of the range (wrap then stays 0).
module jk_reg_bank
    import jk_reg_bank_pkg::*;
#(
    parameter int unsigned      WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic [JK_MODE_W-1:0] mode,
    input  logic [WIDTH-1:0]     j,
    input  logic [WIDTH-1:0]     k,
    input  logic [WIDTH-1:0]     d,
    output logic [WIDTH-1:0]     q,
    output logic                 wrap
);

    jk_mode_e         w_mode;
    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_up_t;
    logic [WIDTH-1:0] w_dn_t;
    logic [WIDTH-1:0] w_j;
    logic [WIDTH-1:0] w_k;
    logic             w_all_ones;
    logic             w_all_zero;
    logic             w_up_hold;
    logic             w_dn_hold;

    assign w_mode     = jk_mode_e'(mode);
    assign w_all_ones = &w_q;
    assign w_all_zero = ~|w_q;

    // Toggle enables: each bit is a flat AND of the lower bits, so synthesis
    // builds a log-depth tree rather than a ripple chain.
    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        if (i == 0) begin : g_lsb
            assign w_up_t[i] = 1'b1;
            assign w_dn_t[i] = 1'b1;
        end else begin : g_upper
            assign w_up_t[i] = &w_q[i-1:0];
            assign w_dn_t[i] = &(~w_q[i-1:0]);
        end
    end

`ifdef JK_REG_BANK_SAT_EN
    // At the range ends the toggle chain is suppressed so the count sticks.
    assign w_up_hold = w_all_ones;
    assign w_dn_hold = w_all_zero;
    assign wrap      = 1'b0;
`else
    logic r_wrap;
    logic w_wrap_d;

    assign w_up_hold = 1'b0;
    assign w_dn_hold = 1'b0;
    assign w_wrap_d  = en & (((w_mode == JK_MODE_UP) & w_all_ones) |
                             ((w_mode == JK_MODE_DOWN) & w_all_zero));

    // Roll-over pulse registered alongside the q update it belongs to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wrap <= 1'b0;
        end else begin
            r_wrap <= w_wrap_d;
        end
    end

    assign wrap = r_wrap;
`endif

    // Per-cell J/K selection for the active bank mode.
    always_comb begin
        w_j = '0;
        w_k = '0;
        unique case (w_mode)
            JK_MODE_JK: begin
                w_j = j;
                w_k = k;
            end
            JK_MODE_UP: begin
                w_j = w_up_t & {WIDTH{~w_up_hold}};
                w_k = w_up_t & {WIDTH{~w_up_hold}};
            end
            JK_MODE_DOWN: begin
                w_j = w_dn_t & {WIDTH{~w_dn_hold}};
                w_k = w_dn_t & {WIDTH{~w_dn_hold}};
            end
            JK_MODE_LOAD: begin
                w_j = d;
                w_k = ~d;
            end
            default: begin
                w_j = '0;
                w_k = '0;
            end
        endcase
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_cell u_cell (
            .clk       (clk),
            .reset     (reset),
            .i_rst_val (RESET_VAL[i]),
            .i_en      (en),
            .i_j       (w_j[i]),
            .i_k       (w_k[i]),
            .o_q       (w_q[i])
        );
    end

    assign q = w_q;

endmodule

// File: tb/tb_jk_reg_bank.sv
// Self-checking bench for jk_reg_bank (WIDTH = 8, RESET_VAL = 8'hA5): directed
// cases followed by random traffic against an arithmetic reference model.
// Honours JK_REG_BANK_SAT_EN in its model when that build is selected.
module tb_jk_reg_bank;

    localparam int unsigned W  = 8;
    localparam logic [7:0]  RV = 8'hA5;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [1:0] mode;
    logic [7:0] j;
    logic [7:0] k;
    logic [7:0] d;
    logic [7:0] q;
    logic       wrap;

    int total = 0;
    int bad   = 0;

    logic [7:0] m_q;
    logic       m_wrap;

    always #5 clk = ~clk;

    jk_reg_bank #(
        .WIDTH     (W),
        .RESET_VAL (RV)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .mode  (mode),
        .j     (j),
        .k     (k),
        .d     (d),
        .q     (q),
        .wrap  (wrap)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, predict the result from the rules, then check.
    task automatic step(input logic e, input logic [1:0] md, input logic [7:0] jj,
                        input logic [7:0] kk, input logic [7:0] dd, input string tag);
        logic [7:0] nq;
        logic       nw;
        en   = e;
        mode = md;
        j    = jj;
        k    = kk;
        d    = dd;
        nq   = m_q;
        nw   = 1'b0;
        if (e) begin
            case (md)
                2'd0: begin
                    for (int b = 0; b < 8; b++) begin
                        if (jj[b] && kk[b])      nq[b] = ~m_q[b];
                        else if (jj[b])          nq[b] = 1'b1;
                        else if (kk[b])          nq[b] = 1'b0;
                    end
                end
                2'd1: begin
`ifdef JK_REG_BANK_SAT_EN
                    nq = (m_q == 8'hFF) ? 8'hFF : m_q + 8'd1;
`else
                    nq = 8'((int'(m_q) + 1) % 256);
                    nw = (m_q == 8'hFF);
`endif
                end
                2'd2: begin
`ifdef JK_REG_BANK_SAT_EN
                    nq = (m_q == 8'h00) ? 8'h00 : m_q - 8'd1;
`else
                    nq = 8'((int'(m_q) + 255) % 256);
                    nw = (m_q == 8'h00);
`endif
                end
                default: nq = dd;
            endcase
        end
        @(posedge clk);
        #1;
        m_q    = nq;
        m_wrap = nw;
        check_val({tag, "_q"}, q, m_q);
        check_val({tag, "_wrap"}, wrap, m_wrap);
    endtask

    initial begin
        reset = 1'b1;
        en    = 1'b0;
        mode  = 2'd0;
        j     = '0;
        k     = '0;
        d     = '0;
        m_q   = RV;
        m_wrap = 1'b0;

        // Reset value must appear before any clock edge.
        #2;
        check_val("reset_q", q, RV);
        check_val("reset_wrap", wrap, 1'b0);
        @(negedge clk);
        check_val("reset_hold_q", q, RV);
        reset = 1'b0;

        // JK mode: set, clear, toggle and hold in one vector.
        step(1'b1, 2'd3, 8'h00, 8'h00, 8'h0F, "load_0f");
        step(1'b1, 2'd0, 8'hF0, 8'h3C, 8'h00, "jk");
        check_val("jk_const", q, 8'hF3);

        // Count up across the top of the range.
        step(1'b1, 2'd3, 8'h00, 8'h00, 8'hFE, "load_fe");
        step(1'b1, 2'd1, 8'h00, 8'h00, 8'h00, "up_ff");
        step(1'b1, 2'd1, 8'h00, 8'h00, 8'h00, "up_wrap");
`ifndef JK_REG_BANK_SAT_EN
        check_val("up_wrap_const_q", q, 8'h00);
        check_val("up_wrap_const_w", wrap, 1'b1);
`endif
        step(1'b1, 2'd1, 8'h00, 8'h00, 8'h00, "up_after");

        // Count down through zero with an enable gap in between.
        step(1'b1, 2'd3, 8'h00, 8'h00, 8'h01, "load_01");
        step(1'b1, 2'd2, 8'h00, 8'h00, 8'h00, "dn_00");
        for (int g = 0; g < 3; g++) begin
            step(1'b0, 2'd2, 8'hFF, 8'hFF, 8'h55, "gap");
        end
        step(1'b1, 2'd2, 8'h00, 8'h00, 8'h00, "dn_wrap");
`ifndef JK_REG_BANK_SAT_EN
        check_val("dn_wrap_const_q", q, 8'hFF);
        check_val("dn_wrap_const_w", wrap, 1'b1);
`endif

        // Reset applied between edges while counting.
        step(1'b1, 2'd3, 8'h00, 8'h00, 8'h10, "load_10");
        step(1'b1, 2'd1, 8'h00, 8'h00, 8'h00, "up_pre");
        #2;
        reset = 1'b1;
        #1;
        check_val("midreset_q", q, RV);
        check_val("midreset_wrap", wrap, 1'b0);
        @(negedge clk);
        reset  = 1'b0;
        m_q    = RV;
        m_wrap = 1'b0;
        step(1'b1, 2'd1, 8'h00, 8'h00, 8'h00, "post_reset_up");
        check_val("post_reset_const", q, 8'hA6);

        // Random traffic; loads are biased toward the range ends to hit wrap.
        for (int n = 0; n < 400; n++) begin
            logic [7:0] rd;
            case ($urandom_range(0, 3))
                0:       rd = 8'hFF;
                1:       rd = 8'h00;
                default: rd = 8'($urandom);
            endcase
            step(($urandom_range(0, 3) != 0), 2'($urandom), 8'($urandom), 8'($urandom), rd,
                 "rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/jk_reg_bank.md
# jk_reg_bank

Parametrised WIDTH-bit register bank built from per-bit JK cells, replacing discrete single-bit JK flops in control paths. Each bit supports the classic JK hold, clear, set and toggle actions. Bank-wide modes add binary up/down counting through the JK toggle chain and a parallel load. A registered wrap pulse flags counter roll-over for downstream sequencing logic.

## Interface
Parameters:
- WIDTH, 8, bank width in bits; legal range 1..32.
- RESET_VAL, '0, value loaded into q on reset; WIDTH bits.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- en  input  1  update enable; 0 holds all state.
- mode  input  2  0 = JK, 1 = count up, 2 = count down, 3 = load.
- j  input  WIDTH  per-bit J; used in JK mode only.
- k  input  WIDTH  per-bit K; used in JK mode only.
- d  input  WIDTH  parallel load data; used in load mode only.
- q  output  WIDTH  bank state, registered.
- wrap  output  1  registered one-cycle pulse on counter roll-over.

## Operation
- Reset: reset is asynchronous and active-high; clock is clk.
- While reset is high: q = RESET_VAL and wrap = 0, independent of clk.
- en = 0: q holds and wrap is 0 on the next edge. Mode, j, k and d are ignored.
- JK mode (en = 1, mode = 0), per bit i, with {j[i],k[i]}:
  - 00: hold.
  - 01: q[i] ← 0.
  - 10: q[i] ← 1.
  - 11: q[i] ← ~q[i].
  - wrap = 0.
- Count up (mode = 1): each cell has J = K = AND of all lower q bits, with bit 0 tied to 1. The result is q ← q + 1 mod 2^WIDTH.
- Count down (mode = 2): each cell has J = K = AND of all lower ~q bits. The result is q ← q − 1 mod 2^WIDTH.
- Load (mode = 3): q ← d; wrap = 0.
- wrap:
  - Asserted for exactly one cycle, on the edge where q transitions from all-ones to 0 (count up) or from 0 to all-ones (count down).
  - Otherwise 0.
  - Consecutive roll-overs, e.g. WIDTH = 1 counting continuously, produce wrap on every roll-over edge.
- Mode changes take effect at the next enabled edge. No state is carried between modes.
- Reset asserted mid-count: q and wrap clear immediately. Counting resumes from RESET_VAL on the first enabled edge after reset deasserts.

## Timing
- Latency from input to q is one clk edge in every mode. There are no combinational paths from inputs to outputs.
- wrap is aligned with the q update that rolls over; both are visible in the same cycle.
- The toggle chain is combinational AND across WIDTH bits. It must close timing at WIDTH = 32 in a single cycle.
- Reset release is synchronous to clk; the first update occurs on the first edge after deassertion.

## Configuration
- JK_REG_BANK_SAT_EN defined: counting saturates instead of wrapping.
  - Count up at all-ones holds all-ones.
  - Count down at 0 holds 0.
  - wrap is tied to 0.
- JK_REG_BANK_SAT_EN undefined: counting wraps modulo 2^WIDTH and wrap is generated as described under Operation.
- JK mode and load mode are identical in both builds.

## Structure
- Shared package jk_reg_bank_pkg contains:
  - the mode enum: JK_MODE_JK, JK_MODE_UP, JK_MODE_DOWN, JK_MODE_LOAD;
  - the 2-bit mode width constant.
- Sub-module jk_cell is a single-bit JK flop with en, async reset and a reset value input. It is instantiated WIDTH times in a generate loop.
- The top level computes per-cell j/k (JK inputs, toggle chain, or load: j = d, k = ~d) and the wrap logic.

## Test plan
- Reset: assert reset with WIDTH = 8, RESET_VAL = 8'hA5 → q = 8'hA5 and wrap = 0 immediately, with no clock edge.
- JK mode: q = 8'h0F; j = 8'hF0, k = 8'h3C → next edge q = 8'hF3. This covers the set, clear, toggle and hold combinations per bit.
- Count up wrap: load 8'hFE, then count up for 2 edges → q = 8'hFF then 8'h00, with wrap high only on the second edge.
- Count down wrap with en gap: start at 8'h01, count down, hold en = 0 for 3 cycles, count down again → q = 8'h00 then 8'hFF; q is stable during the gap and wrap pulses once.
- Mid-count reset: assert reset asynchronously between edges while counting → q returns to RESET_VAL immediately; the next enabled edge after release gives RESET_VAL + 1.
- Saturation build with JK_REG_BANK_SAT_EN: count up from 8'hFF → q stays 8'hFF; count down from 0 → q stays 0; wrap stays 0 throughout.
